// File: rtl/pipeline_pkg.sv
// Shared types for the five-stage pipeline hazard unit: forwarding select codes,
// the scoreboard entry carried through EX/MEM/WB, and the stage enumeration.
package pipeline_pkg;

    // Scoreboard register fields are held at this width; REG_ADDR_W must not exceed it.
    localparam int SB_ADDR_W = 8;

    localparam logic [1:0] FWD_REG   = 2'b00;
    localparam logic [1:0] FWD_EXMEM = 2'b01;
    localparam logic [1:0] FWD_MEMWB = 2'b10;

    typedef enum logic [1:0] {
        STG_EX  = 2'd0,
        STG_MEM = 2'd1,
        STG_WB  = 2'd2
    } stage_e;

    typedef struct packed {
        logic                 valid;
        logic [SB_ADDR_W-1:0] rs;
        logic [SB_ADDR_W-1:0] rt;
        logic                 use_rs;
        logic                 use_rt;
        logic [SB_ADDR_W-1:0] dest;
        logic                 regwrite;
        logic                 memread;
    } sb_entry_t;

    // A stage produces register r; $0 is never a real producer.
    function automatic logic writes(input sb_entry_t e, input logic [SB_ADDR_W-1:0] r);
        return e.valid && e.regwrite && (e.dest == r) && (r != '0);
    endfunction

endpackage

// File: rtl/hazard_sb_stage.sv
// One scoreboard entry of the hazard unit; loads the upstream entry each clock
// or an all-zero bubble when the stage is flushed.
module hazard_sb_stage
    import pipeline_pkg::*;
(
    input  logic      clk,
    input  logic      rst,
    input  sb_entry_t d,
    input  logic      bubble,
    output sb_entry_t q
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q <= '0;
        end else if (bubble) begin
            q <= '0;
        end else begin
            q <= d;
        end
    end

endmodule

// File: rtl/pipeline_hazard_unit.sv
// Hazard detection, operand forwarding and flush control for the IF/ID/EX/MEM/WB
// pipeline, with saturating stall and flush statistics.
module pipeline_hazard_unit
    import pipeline_pkg::*;
#(
    parameter int REG_ADDR_W = 5,
    parameter bit FWD_EN     = 1'b1,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  id_valid,
    input  logic [REG_ADDR_W-1:0] id_rs,
    input  logic [REG_ADDR_W-1:0] id_rt,
    input  logic                  id_use_rs,
    input  logic                  id_use_rt,
    input  logic [REG_ADDR_W-1:0] id_dest,
    input  logic                  id_regwrite,
    input  logic                  id_memread,
    input  logic                  redirect_ex,
    input  logic                  redirect_mem,
    output logic                  pc_en,
    output logic                  if_id_en,
    output logic                  if_id_flush,
    output logic                  id_ex_flush,
    output logic                  ex_mem_flush,
    output logic [1:0]            fwd_a,
    output logic [1:0]            fwd_b,
    output logic                  id_byp_a,
    output logic                  id_byp_b,
    output logic [CNT_WIDTH-1:0]  stall_cnt,
    output logic [CNT_WIDTH-1:0]  flush_cnt
);

    sb_entry_t id_entry;
    sb_entry_t sb [3];
    logic      load_use;
    logic      raw_any;
    logic      stall;
    logic      stall_active;
    logic      flush_active;

    always_comb begin
        id_entry          = '0;
        id_entry.valid    = id_valid;
        id_entry.rs       = SB_ADDR_W'(id_rs);
        id_entry.rt       = SB_ADDR_W'(id_rt);
        id_entry.use_rs   = id_use_rs;
        id_entry.use_rt   = id_use_rt;
        id_entry.dest     = SB_ADDR_W'(id_dest);
        id_entry.regwrite = id_regwrite;
        id_entry.memread  = id_memread;
    end

    hazard_sb_stage u_sb_ex (
        .clk    (clk),
        .rst    (reset),
        .d      (id_entry),
        .bubble (id_ex_flush || !id_valid),
        .q      (sb[STG_EX])
    );

    hazard_sb_stage u_sb_mem (
        .clk    (clk),
        .rst    (reset),
        .d      (sb[STG_EX]),
        .bubble (ex_mem_flush),
        .q      (sb[STG_MEM])
    );

    hazard_sb_stage u_sb_wb (
        .clk    (clk),
        .rst    (reset),
        .d      (sb[STG_MEM]),
        .bubble (1'b0),
        .q      (sb[STG_WB])
    );

    always_comb begin
        load_use = sb[STG_EX].memread &&
                   ((id_use_rs && writes(sb[STG_EX], id_entry.rs)) ||
                    (id_use_rt && writes(sb[STG_EX], id_entry.rt)));
        raw_any  = (id_use_rs && (writes(sb[STG_EX], id_entry.rs) || writes(sb[STG_MEM], id_entry.rs))) ||
                   (id_use_rt && (writes(sb[STG_EX], id_entry.rt) || writes(sb[STG_MEM], id_entry.rt)));
        stall    = id_valid && (FWD_EN ? load_use : raw_any);
    end

    // Reset forces the benign control values even if redirects are asserted.
    always_comb begin
        pc_en        = 1'b1;
        if_id_en     = 1'b1;
        if_id_flush  = 1'b0;
        id_ex_flush  = 1'b0;
        ex_mem_flush = 1'b0;
        stall_active = 1'b0;
        flush_active = 1'b0;
        if (!reset) begin
            if (redirect_mem) begin
                if_id_flush  = 1'b1;
                id_ex_flush  = 1'b1;
                ex_mem_flush = 1'b1;
                flush_active = 1'b1;
            end else if (redirect_ex) begin
                if_id_flush  = 1'b1;
                id_ex_flush  = 1'b1;
                flush_active = 1'b1;
            end else if (stall) begin
                pc_en        = 1'b0;
                if_id_en     = 1'b0;
                id_ex_flush  = 1'b1;
                stall_active = 1'b1;
            end
        end
    end

    // MEM holds the younger result, so it wins over WB.
    always_comb begin
        fwd_a = FWD_REG;
        fwd_b = FWD_REG;
        if (FWD_EN && !reset) begin
            if (sb[STG_EX].use_rs && writes(sb[STG_MEM], sb[STG_EX].rs)) begin
                fwd_a = FWD_EXMEM;
            end else if (writes(sb[STG_WB], sb[STG_EX].rs)) begin
                fwd_a = FWD_MEMWB;
            end
            if (sb[STG_EX].use_rt && writes(sb[STG_MEM], sb[STG_EX].rt)) begin
                fwd_b = FWD_EXMEM;
            end else if (writes(sb[STG_WB], sb[STG_EX].rt)) begin
                fwd_b = FWD_MEMWB;
            end
        end
    end

    always_comb begin
        id_byp_a = !reset && id_use_rs && writes(sb[STG_WB], id_entry.rs);
        id_byp_b = !reset && id_use_rt && writes(sb[STG_WB], id_entry.rt);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (stall_active && (stall_cnt != '1)) begin
                stall_cnt <= stall_cnt + CNT_WIDTH'(1);
            end
            if (flush_active && (flush_cnt != '1)) begin
                flush_cnt <= flush_cnt + CNT_WIDTH'(1);
            end
        end
    end

endmodule

// File: tb/tb_pipeline_hazard_unit.sv
// Bench for pipeline_hazard_unit: one forwarding instance (4-bit counters) and one
// stall-only instance, checked cycle by cycle against a queue of expected controls.
module tb_pipeline_hazard_unit;

    typedef struct packed {
        logic       valid;
        logic [4:0] rs;
        logic [4:0] rt;
        logic       use_rs;
        logic       use_rt;
        logic [4:0] dest;
        logic       regwrite;
        logic       memread;
        logic       rex;
        logic       rmem;
    } id_in_t;

    typedef struct {
        bit          which;
        logic [10:0] exp;
        string       tag;
    } exp_t;

    logic   clk = 1'b0;
    logic   rst;
    id_in_t in_f;
    id_in_t in_n;

    logic       pc_en_f, if_id_en_f, if_id_flush_f, id_ex_flush_f, ex_mem_flush_f, byp_a_f, byp_b_f;
    logic [1:0] fwd_a_f, fwd_b_f;
    logic [3:0] stall_cnt_f, flush_cnt_f;
    logic       pc_en_n, if_id_en_n, if_id_flush_n, id_ex_flush_n, ex_mem_flush_n, byp_a_n, byp_b_n;
    logic [1:0] fwd_a_n, fwd_b_n;
    logic [15:0] stall_cnt_n, flush_cnt_n;

    logic [10:0] ctl_f, ctl_n;
    assign ctl_f = {pc_en_f, if_id_en_f, if_id_flush_f, id_ex_flush_f, ex_mem_flush_f,
                    fwd_a_f, fwd_b_f, byp_a_f, byp_b_f};
    assign ctl_n = {pc_en_n, if_id_en_n, if_id_flush_n, id_ex_flush_n, ex_mem_flush_n,
                    fwd_a_n, fwd_b_n, byp_a_n, byp_b_n};

    int   checks = 0;
    int   failures = 0;
    exp_t expq[$];

    always #5 clk = ~clk;

    pipeline_hazard_unit #(.REG_ADDR_W(5), .FWD_EN(1'b1), .CNT_WIDTH(4)) dut_f (
        .clk(clk), .reset(rst), .id_valid(in_f.valid), .id_rs(in_f.rs), .id_rt(in_f.rt),
        .id_use_rs(in_f.use_rs), .id_use_rt(in_f.use_rt), .id_dest(in_f.dest),
        .id_regwrite(in_f.regwrite), .id_memread(in_f.memread),
        .redirect_ex(in_f.rex), .redirect_mem(in_f.rmem),
        .pc_en(pc_en_f), .if_id_en(if_id_en_f), .if_id_flush(if_id_flush_f),
        .id_ex_flush(id_ex_flush_f), .ex_mem_flush(ex_mem_flush_f),
        .fwd_a(fwd_a_f), .fwd_b(fwd_b_f), .id_byp_a(byp_a_f), .id_byp_b(byp_b_f),
        .stall_cnt(stall_cnt_f), .flush_cnt(flush_cnt_f)
    );

    pipeline_hazard_unit #(.REG_ADDR_W(5), .FWD_EN(1'b0), .CNT_WIDTH(16)) dut_n (
        .clk(clk), .reset(rst), .id_valid(in_n.valid), .id_rs(in_n.rs), .id_rt(in_n.rt),
        .id_use_rs(in_n.use_rs), .id_use_rt(in_n.use_rt), .id_dest(in_n.dest),
        .id_regwrite(in_n.regwrite), .id_memread(in_n.memread),
        .redirect_ex(in_n.rex), .redirect_mem(in_n.rmem),
        .pc_en(pc_en_n), .if_id_en(if_id_en_n), .if_id_flush(if_id_flush_n),
        .id_ex_flush(id_ex_flush_n), .ex_mem_flush(ex_mem_flush_n),
        .fwd_a(fwd_a_n), .fwd_b(fwd_b_n), .id_byp_a(byp_a_n), .id_byp_b(byp_b_n),
        .stall_cnt(stall_cnt_n), .flush_cnt(flush_cnt_n)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [10:0] ctl(input bit pc, input bit ifid, input bit fif, input bit fex,
                                        input bit fmem, input logic [1:0] fa, input logic [1:0] fb,
                                        input bit ba, input bit bb);
        return {pc, ifid, fif, fex, fmem, fa, fb, ba, bb};
    endfunction

    function automatic id_in_t ins(input int rs, input int rt, input bit urs, input bit urt,
                                   input int dest, input bit rw, input bit mr);
        id_in_t t;
        t          = '0;
        t.valid    = 1'b1;
        t.rs       = 5'(rs);
        t.rt       = 5'(rt);
        t.use_rs   = urs;
        t.use_rt   = urt;
        t.dest     = 5'(dest);
        t.regwrite = rw;
        t.memread  = mr;
        return t;
    endfunction

    // Scoreboard side: every cycle with a pending expectation is compared mid-cycle.
    always @(negedge clk) begin
        if (expq.size() > 0) begin
            exp_t e;
            e = expq.pop_front();
            chk(e.tag, 32'(e.which ? ctl_n : ctl_f), 32'(e.exp));
        end
    end

    task automatic drive(input bit which, input id_in_t in, input logic [10:0] exp, input string tag);
        if (which) begin
            in_n = in;
            in_f = '0;
        end else begin
            in_f = in;
            in_n = '0;
        end
        expq.push_back('{which, exp, tag});
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst  = 1'b1;
        in_f = '0;
        in_n = '0;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired got=running expected=finished");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1);
    end

    initial begin
        id_in_t nop, add3, sub4, and7, lw2, add22, or6, lw0, add00, t;
        logic [10:0] norm, stl;
        nop   = '0;
        add3  = ins(1, 2, 1, 1, 3, 1, 0);
        sub4  = ins(3, 5, 1, 1, 4, 1, 0);
        and7  = ins(8, 9, 1, 1, 7, 1, 0);
        lw2   = ins(1, 0, 1, 0, 2, 1, 1);
        add22 = ins(2, 2, 1, 1, 4, 1, 0);
        or6   = ins(3, 0, 1, 1, 6, 1, 0);
        lw0   = ins(1, 0, 1, 0, 0, 1, 1);
        add00 = ins(0, 0, 1, 1, 4, 1, 0);
        norm  = ctl(1, 1, 0, 0, 0, 2'b00, 2'b00, 0, 0);
        stl   = ctl(0, 0, 0, 1, 0, 2'b00, 2'b00, 0, 0);

        // Reset state, with a redirect asserted to show reset masks it.
        rst  = 1'b1;
        in_n = nop;
        in_f = nop;
        in_f.rmem = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ctl", 32'(ctl_f), 32'(norm));
        chk("rst_stall_cnt", 32'(stall_cnt_f), 32'd0);
        chk("rst_flush_cnt", 32'(flush_cnt_f), 32'd0);
        in_f = nop;
        rst  = 1'b0;

        // Forward from MEM, then from WB across one independent instruction.
        do_reset();
        drive(0, add3, norm, "t1_add");
        drive(0, sub4, norm, "t1_sub_no_stall");
        drive(0, nop, ctl(1, 1, 0, 0, 0, 2'b01, 2'b00, 0, 0), "t1_fwd_mem");
        drive(0, nop, norm, "t1_drain");
        do_reset();
        drive(0, add3, norm, "t1b_add");
        drive(0, and7, norm, "t1b_and");
        drive(0, sub4, norm, "t1b_sub");
        drive(0, nop, ctl(1, 1, 0, 0, 0, 2'b10, 2'b00, 0, 0), "t1b_fwd_wb");

        // Load-use: one stall, then WB forwarding of both operands.
        do_reset();
        drive(0, lw2, norm, "t2_lw");
        drive(0, add22, stl, "t2_stall");
        drive(0, add22, norm, "t2_release");
        drive(0, nop, ctl(1, 1, 0, 0, 0, 2'b10, 2'b10, 0, 0), "t2_fwd");
        chk("t2_stall_cnt", 32'(stall_cnt_f), 32'd1);

        // Stall-only mode: EX dependency stalls twice, MEM dependency once.
        do_reset();
        drive(1, add3, norm, "t3_add");
        drive(1, or6, stl, "t3_stall1");
        drive(1, or6, stl, "t3_stall2");
        drive(1, or6, ctl(1, 1, 0, 0, 0, 2'b00, 2'b00, 1, 0), "t3_byp");
        drive(1, nop, norm, "t3_nofwd");
        chk("t3_stall_cnt", 32'(stall_cnt_n), 32'd2);
        drive(1, add3, norm, "t3b_add");
        drive(1, and7, norm, "t3b_and");
        drive(1, or6, stl, "t3b_stall_mem");
        drive(1, or6, ctl(1, 1, 0, 0, 0, 2'b00, 2'b00, 1, 0), "t3b_byp");
        chk("t3b_stall_cnt", 32'(stall_cnt_n), 32'd3);

        // Redirect priority over a load-use stall, redirect_ex alone, both together.
        do_reset();
        drive(0, lw2, norm, "t4_lw");
        t = add22;
        t.rmem = 1'b1;
        drive(0, t, ctl(1, 1, 1, 1, 1, 2'b00, 2'b00, 0, 0), "t4_rmem_over_stall");
        t = nop;
        t.rex = 1'b1;
        drive(0, t, ctl(1, 1, 1, 1, 0, 2'b00, 2'b00, 0, 0), "t4_rex");
        t.rmem = 1'b1;
        drive(0, t, ctl(1, 1, 1, 1, 1, 2'b00, 2'b00, 0, 0), "t4_both");
        drive(0, nop, norm, "t4_drain");
        chk("t4_stall_cnt", 32'(stall_cnt_f), 32'd0);
        chk("t4_flush_cnt", 32'(flush_cnt_f), 32'd3);

        // Register 0 never stalls, forwards or bypasses.
        do_reset();
        drive(0, lw0, norm, "t5_lw0");
        drive(0, add00, norm, "t5_no_load_use");
        drive(0, nop, norm, "t5_no_fwd_mem");
        drive(0, lw0, norm, "t5_lw0_b");
        drive(0, nop, norm, "t5_gap");
        drive(0, add00, norm, "t5_add00");
        drive(0, add00, norm, "t5_no_fwd_wb_no_byp");

        // Asynchronous reset in the middle of a load-use stall.
        do_reset();
        t = nop;
        t.rex = 1'b1;
        drive(0, t, ctl(1, 1, 1, 1, 0, 2'b00, 2'b00, 0, 0), "t6_rex");
        drive(0, lw2, norm, "t6_lw");
        drive(0, add22, stl, "t6_stall");
        drive(0, add22, norm, "t6_release");
        drive(0, lw2, ctl(1, 1, 0, 0, 0, 2'b10, 2'b10, 0, 0), "t6_fwd");
        chk("t6_pre_stall_cnt", 32'(stall_cnt_f), 32'd1);
        chk("t6_pre_flush_cnt", 32'(flush_cnt_f), 32'd1);
        in_f = add22;
        #2;
        chk("t6_mid_stall", 32'(ctl_f), 32'(stl));
        rst = 1'b1;
        #1;
        chk("t6_rst_async_ctl", 32'(ctl_f), 32'(norm));
        chk("t6_rst_stall_cnt", 32'(stall_cnt_f), 32'd0);
        chk("t6_rst_flush_cnt", 32'(flush_cnt_f), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        drive(0, add22, norm, "t6_post_rst_no_stall");

        // 20 load-use pairs against a 4-bit stall counter.
        do_reset();
        for (int i = 0; i < 20; i++) begin
            drive(0, lw2, norm, "t7_lw");
            drive(0, add22, stl, "t7_stall");
            drive(0, add22, norm, "t7_release");
            drive(0, nop, ctl(1, 1, 0, 0, 0, 2'b10, 2'b10, 0, 0), "t7_fwd");
            chk("t7_stall_cnt", 32'(stall_cnt_f), (i + 1 > 15) ? 32'd15 : 32'(i + 1));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
